// File: rtl/quad_decoder_pkg.sv
// quad_pkg: Gray-code state constants, decode result type and transition decoder
package quad_pkg;
  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S01 = 2'b01;
  localparam logic [1:0] S11 = 2'b11;
  localparam logic [1:0] S10 = 2'b10;
  typedef enum logic [1:0] {NONE, UP, DOWN, ILLEGAL} step_e;
  function automatic step_e decode(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] nxt_up;
    nxt_up = prev == S00 ? S01 : prev == S01 ? S11 : prev == S11 ? S10 : S00;
    return cur == prev ? NONE : (cur ^ prev) == 2'b11 ? ILLEGAL : cur == nxt_up ? UP : DOWN;
  endfunction
endpackage

// File: rtl/quad_decoder_if.sv
// quad_decoder_if: encoder phases, counter controls and position/status outputs
interface quad_decoder_if #(parameter int WIDTH = 8);
  logic             a_in;
  logic             b_in;
  logic             en;
  logic             ld;
  logic             clr;
  logic [WIDTH-1:0] d_in;
  logic             err_clr;
  logic [WIDTH-1:0] count;
  logic             dir;
  logic             step;
  logic             err;
  modport master (output a_in, b_in, en, ld, clr, d_in, err_clr, input count, dir, step, err);
  modport slave  (input a_in, b_in, en, ld, clr, d_in, err_clr, output count, dir, step, err);
endinterface

// File: rtl/quad_decoder_sync_ff.sv
// sync_ff: multi-stage synchroniser for one asynchronous bit
module sync_ff #(parameter int STAGES = 2) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sh_q;
  // shift the input through the flop chain
  always_ff @(posedge clk or posedge rst)
    if (rst) sh_q <= '0;
    else     sh_q <= {sh_q[STAGES-2:0], d_i};
  assign q_o = sh_q[STAGES-1];
endmodule

// File: rtl/quad_decoder.sv
// quad_decoder: quadrature decode into a loadable, clearable up/down position counter
module quad_decoder
  import quad_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic          clk,
  input logic          rst,
  quad_decoder_if.slave bus
);
  localparam int PW = $clog2(SYNC_STAGES + 2);
  localparam logic [PW-1:0] PRIME_END = PW'(SYNC_STAGES + 1);
  logic             a_s, b_s;
  logic [1:0]       s, prev_q, prev_d;
  logic [PW-1:0]    prime_q, prime_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d, step_q, step_d, err_q, err_d;
  logic             priming, legal;
  step_e            ev;
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_a (.clk(clk), .rst(rst), .d_i(bus.a_in), .q_o(a_s));
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_b (.clk(clk), .rst(rst), .d_i(bus.b_in), .q_o(b_s));
  assign s = {a_s, b_s};
  // the synchroniser needs SYNC_STAGES edges to fill and one more to load prev with a real sample
  assign priming = prime_q != PRIME_END;
  // decode the transition and compute next counter/flag state
  always_comb begin
    ev      = priming ? NONE : decode(prev_q, s);
    legal   = ev == UP || ev == DOWN;
    prev_d  = s;
    prime_d = priming ? prime_q + PW'(1) : prime_q;
    count_d = bus.ld ? bus.d_in :
              bus.clr ? '0 :
              (bus.en && ev == UP) ? count_q + WIDTH'(1) :
              (bus.en && ev == DOWN) ? count_q - WIDTH'(1) : count_q;
    step_d  = bus.en && !bus.ld && !bus.clr && legal;
    dir_d   = ev == UP ? 1'b1 : ev == DOWN ? 1'b0 : dir_q;
    err_d   = ev == ILLEGAL ? 1'b1 : bus.err_clr ? 1'b0 : err_q;
  end
  // state registers; reset discards any transition still in the synchroniser
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prev_q  <= S00;
      prime_q <= '0;
      count_q <= '0;
      dir_q   <= 1'b1;
      step_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      prime_q <= prime_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      err_q   <= err_d;
    end
  assign bus.count = count_q;
  assign bus.dir   = dir_q;
  assign bus.step  = step_q;
  assign bus.err   = err_q;
endmodule
